// File: rtl/seven_seg_pkg.sv
// ----------------------------------------------------------------------------
// seven_seg_pkg
//
// Shared definitions for the heartbeat display sequencer. It holds the
// sequencer state encoding, the frame constants driven onto the display mux,
// and small helpers that map a state to its frame.
//
// Optional build macro: HEARTBEAT_DOUBLE_EN
//   Defined   -> adds the GAP / BEAT2_IN / BEAT2_OUT states ("lub-dub").
//   Undefined -> those states and their encodings do not exist.
// ----------------------------------------------------------------------------
package seven_seg_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        BEAT_IN   = 3'd1,
        BEAT_OUT  = 3'd2,
        BEAT_BACK = 3'd3,
        REST      = 3'd4
`ifdef HEARTBEAT_DOUBLE_EN
        ,
        GAP       = 3'd5,
        BEAT2_IN  = 3'd6,
        BEAT2_OUT = 3'd7
`endif
    } hb_state_t;

    // an_en selects which digits are lit; line picks the bar side per digit
    // (0 = left bar, 1 = right bar), bit 3 is the leftmost digit.
    localparam logic [3:0] AN_BLANK   = 4'b0000;
    localparam logic [3:0] AN_INNER   = 4'b0110;
    localparam logic [3:0] AN_OUTER   = 4'b1001;
    localparam logic [3:0] LINE_BLANK = 4'b0000;
    localparam logic [3:0] LINE_INNER = 4'b0010;
    localparam logic [3:0] LINE_OUTER = 4'b0001;

    function automatic logic [3:0] frame_an(input hb_state_t s);
        logic [3:0] an;
        an = AN_BLANK;
        case (s)
            BEAT_IN, BEAT_BACK: an = AN_INNER;
            BEAT_OUT:           an = AN_OUTER;
`ifdef HEARTBEAT_DOUBLE_EN
            BEAT2_IN:           an = AN_INNER;
            BEAT2_OUT:          an = AN_OUTER;
`endif
            default:            an = AN_BLANK;
        endcase
        return an;
    endfunction

    function automatic logic [3:0] frame_line(input hb_state_t s);
        logic [3:0] ln;
        ln = LINE_BLANK;
        case (s)
            BEAT_IN, BEAT_BACK: ln = LINE_INNER;
            BEAT_OUT:           ln = LINE_OUTER;
`ifdef HEARTBEAT_DOUBLE_EN
            BEAT2_IN:           ln = LINE_INNER;
            BEAT2_OUT:          ln = LINE_OUTER;
`endif
            default:            ln = LINE_BLANK;
        endcase
        return ln;
    endfunction

    // States whose entry produces the one-cycle beat pulse.
    function automatic logic is_beat_state(input hb_state_t s);
        logic b;
        b = (s == BEAT_OUT);
`ifdef HEARTBEAT_DOUBLE_EN
        b = b || (s == BEAT2_OUT);
`endif
        return b;
    endfunction

endpackage

// File: rtl/heartbeat_tick_gen.sv
// ----------------------------------------------------------------------------
// heartbeat_tick_gen
//
// Frame-rate prescaler. While enabled it counts 0..P-1 and raises tick for
// the single cycle in which the count sits at P-1, where
// P = max(1, TICK_DIV >> rs_q). rs_q is a private copy of rate_sel that is
// refreshed only while disabled and at every tick, so a rate change never
// stretches or cuts short the frame already in progress.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset
//   enable   in   count when high; count held at 0 when low
//   rate_sel in   [1:0] frame period divider exponent
//   tick     out  one-cycle frame tick
// ----------------------------------------------------------------------------
module heartbeat_tick_gen #(
    parameter int TICK_DIV = 50_000_000,
    parameter int CW       = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] rate_sel,
    output logic       tick
);

    localparam logic [CW-1:0] DIV = CW'(TICK_DIV);

    logic [CW-1:0] count;
    logic [CW-1:0] period;
    logic [1:0]    rs_q;

    // Large rate_sel values can shift a small TICK_DIV down to zero; clamp
    // the period to one cycle so a tick still fires every cycle.
    always_comb begin
        period = DIV >> rs_q;
        if (period == '0) begin
            period = CW'(1);
        end
    end

    assign tick = enable && (count == (period - CW'(1)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            rs_q  <= 2'd0;
        end else if (!enable) begin
            count <= '0;
            rs_q  <= rate_sel;
        end else if (tick) begin
            count <= '0;
            rs_q  <= rate_sel;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/seven_seg_heartbeat_ctrl.sv
// ----------------------------------------------------------------------------
// seven_seg_heartbeat_ctrl
//
// Animates the 4-digit heartbeat display: inner bars, outer bars, inner bars,
// then a rest of REST_TICKS blank frames, repeating while run is high. Each
// frame lasts one prescaler tick period. All outputs are registered and are
// loaded from the next state, so they change on the same edge as the state.
//
// Optional build macro: HEARTBEAT_DOUBLE_EN
//   Adds a second beat after a one-frame gap ("lub-dub").
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset
//   run      in   level enable; examined in IDLE and at the last REST tick
//   rate_sel in   [1:0] frame period = max(1, TICK_DIV >> rate_sel)
//   line     out  [3:0] per-digit bar side to the display mux
//   an_en    out  [3:0] per-digit enable to the display mux
//   beat     out  one-cycle pulse on entry to an outer-bar beat frame
//   busy     out  high whenever the sequencer is not IDLE
// ----------------------------------------------------------------------------
module seven_seg_heartbeat_ctrl
    import seven_seg_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int REST_TICKS = 2,
    parameter int CW         = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] rate_sel,
    output logic [3:0] line,
    output logic [3:0] an_en,
    output logic       beat,
    output logic       busy
);

    localparam int             RCW       = (REST_TICKS > 1) ? $clog2(REST_TICKS) : 1;
    localparam logic [RCW-1:0] REST_LAST = RCW'(REST_TICKS - 1);

    hb_state_t      state;
    hb_state_t      next_state;
    logic [RCW-1:0] rest_cnt;
    logic           tick;

    heartbeat_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .CW       (CW)
    ) u_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .enable   (state != IDLE),
        .rate_sel (rate_sel),
        .tick     (tick)
    );

    // IDLE leaves immediately on run; every other state advances on a tick.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (run)  next_state = BEAT_IN;
            BEAT_IN:   if (tick) next_state = BEAT_OUT;
            BEAT_OUT:  if (tick) next_state = BEAT_BACK;
`ifdef HEARTBEAT_DOUBLE_EN
            BEAT_BACK: if (tick) next_state = GAP;
            GAP:       if (tick) next_state = BEAT2_IN;
            BEAT2_IN:  if (tick) next_state = BEAT2_OUT;
            BEAT2_OUT: if (tick) next_state = REST;
`else
            BEAT_BACK: if (tick) next_state = REST;
`endif
            REST: begin
                if (tick && (rest_cnt == REST_LAST)) begin
                    next_state = run ? BEAT_IN : IDLE;
                end
            end
            default:   next_state = IDLE;
        endcase
    end

    // State, rest counter and registered outputs. The rest counter sits at 0
    // outside REST, so entry into REST always starts a fresh count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rest_cnt <= '0;
            line     <= LINE_BLANK;
            an_en    <= AN_BLANK;
            beat     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state <= next_state;
            if (state != REST) begin
                rest_cnt <= '0;
            end else if (tick) begin
                rest_cnt <= rest_cnt + RCW'(1);
            end
            line  <= frame_line(next_state);
            an_en <= frame_an(next_state);
            beat  <= (next_state != state) && is_beat_state(next_state);
            busy  <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_seven_seg_heartbeat_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_heartbeat_ctrl
//
// Directed bench for the heartbeat sequencer with TICK_DIV=4, REST_TICKS=2.
// Expected behaviour is written as per-cycle character strings:
//   Z = idle/blank, B = busy blank, I = inner bars, O = outer bars,
//   P = outer bars with the beat pulse.
// Optional build macro: HEARTBEAT_DOUBLE_EN selects the lub-dub expectations.
// ----------------------------------------------------------------------------
module tb_seven_seg_heartbeat_ctrl;

    logic       clk;
    logic       reset;
    logic       run;
    logic [1:0] rate_sel;
    logic [3:0] line;
    logic [3:0] an_en;
    logic       beat;
    logic       busy;

    int vectors;
    int miscompares;

    seven_seg_heartbeat_ctrl #(
        .TICK_DIV   (4),
        .REST_TICKS (2),
        .CW         (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .rate_sel (rate_sel),
        .line     (line),
        .an_en    (an_en),
        .beat     (beat),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs {busy, beat, an_en, line} for one expected character.
    function automatic logic [9:0] expected_of(input byte c);
        logic [9:0] e;
        case (c)
            "B":     e = {1'b1, 1'b0, 4'b0000, 4'b0000};
            "I":     e = {1'b1, 1'b0, 4'b0110, 4'b0010};
            "O":     e = {1'b1, 1'b0, 4'b1001, 4'b0001};
            "P":     e = {1'b1, 1'b1, 4'b1001, 4'b0001};
            default: e = {1'b0, 1'b0, 4'b0000, 4'b0000};
        endcase
        return e;
    endfunction

    // Advances one clock per character and compares just after the edge.
    task automatic applyStimulus(input string tag, input string pat);
        logic [9:0] obs;
        logic [9:0] exp_v;
        for (int i = 0; i < pat.len(); i++) begin
            @(posedge clk);
            #1;
            obs   = {busy, beat, an_en, line};
            exp_v = expected_of(pat[i]);
            vectors++;
            assert (obs === exp_v) else begin
                miscompares++;
                $error("[TB] FAIL %s[%0d] observed=%b expected=%b", tag, i, obs, exp_v);
            end
        end
    endtask

    string seq_period;
    string seq_drop_tail;
    string seq_rate_p2;
    string seq_rate_p1;

    initial begin
        vectors     = 0;
        miscompares = 0;
`ifdef HEARTBEAT_DOUBLE_EN
        seq_period    = "IIIIPOOOIIIIBBBBIIIIPOOOBBBBBBBB";
        seq_drop_tail = "OOIIIIBBBBIIIIPOOOBBBBBBBBZZZZZZ";
        seq_rate_p2   = "IIPOIIBBIIPOBBBBII";
        seq_rate_p1   = "PIBIPBBI";
`else
        seq_period    = "IIIIPOOOIIIIBBBBBBBB";
        seq_drop_tail = "OOIIIIBBBBBBBBZZZZZZ";
        seq_rate_p2   = "IIPOIIBBBBII";
        seq_rate_p1   = "PIBBIP";
`endif

        reset    = 1'b0;
        run      = 1'b0;
        rate_sel = 2'd0;

        // Reset state, checked while reset is held low.
        applyStimulus("reset_hold", "ZZ");

        // Release reset with run high: free-running beats, two full periods.
        reset = 1'b1;
        run   = 1'b1;
        applyStimulus("steady_p1", seq_period);
        applyStimulus("steady_p2", seq_period);

        // One-cycle reset in BEAT_BACK, then a clean restart.
        applyStimulus("pre_reset", "IIIIPOOOII");
        reset = 1'b0;
        applyStimulus("reset_mid", "Z");
        reset = 1'b1;

        // Restarted beat has a full 4-cycle first frame; drop run in BEAT_OUT.
        applyStimulus("restart", "IIIIPO");
        run = 1'b0;
        applyStimulus("run_drop", seq_drop_tail);

        // From IDLE, start at rate 0 and switch to rate 1 inside BEAT_IN.
        run = 1'b1;
        applyStimulus("rate_start", "II");
        rate_sel = 2'd1;
        applyStimulus("rate_p2", seq_rate_p2);

        // Rate 3 shifts TICK_DIV=4 to zero: period clamps to one cycle.
        rate_sel = 2'd3;
        applyStimulus("rate_clamp", seq_rate_p1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_seg_heartbeat_ctrl.md
Name: seven_seg_heartbeat_ctrl

Overview:
Sequencer that animates the 4-digit square-segment heartbeat display. It generates per-frame `line[3:0]` and `an_en[3:0]` patterns for the existing multiplexed heartbeat display driver, stepping them at a programmable tick rate. The result is a repeating "beat" (inner bars, then outer bars, then inner bars, then rest). It sits between top-level switch/control logic and the display mux. It replaces hard-wired switch inputs on `line`/`an_en`.

Parameters:
- TICK_DIV, 50_000_000, base frame period in clk cycles at rate_sel=0 (must be >= 1).
- REST_TICKS, 2, number of frame ticks spent in REST between beats (must be >= 1).
- CW, 26, prescaler counter width; must satisfy 2^CW > TICK_DIV.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- run  input  1  level enable for the animation.
- rate_sel  input  2  frame period = max(1, TICK_DIV >> rate_sel) cycles.
- line  output  4  per-digit bar side, to display mux (0 = left bar, 1 = right bar); bit3 = leftmost digit.
- an_en  output  4  per-digit enable, to display mux.
- beat  output  1  one-cycle pulse on entry to BEAT_OUT.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE; prescaler=0; rest counter=0; line=4'b0000; an_en=4'b0000; beat=0; busy=0. Reset overrides everything, including mid-beat.
- All outputs are registered and change only on clk edges.
- Frame constants:
  - BLANK: an_en=0000, line=0000.
  - INNER: an_en=0110, line=0010 (digit2 left bar, digit1 right bar).
  - OUTER: an_en=1001, line=0001 (digit3 left bar, digit0 right bar).
- Prescaler:
  - Counts 0..P-1 while state != IDLE, where P = max(1, TICK_DIV >> rs_q).
  - "tick" = prescaler at P-1. On a tick the prescaler returns to 0.
  - rs_q samples rate_sel on entry from IDLE and at every tick. A rate change therefore affects the following frame only.
  - In IDLE the prescaler is held at 0.
- FSM (one frame per tick unless stated otherwise):
  - IDLE: outputs BLANK. If run==1, go to BEAT_IN on the next edge, with no tick wait.
  - BEAT_IN: outputs INNER. On tick, go to BEAT_OUT and pulse beat=1 for exactly that one cycle.
  - BEAT_OUT: outputs OUTER. On tick, go to BEAT_BACK.
  - BEAT_BACK: outputs INNER. On tick, go to REST with rest counter=0.
  - REST: outputs BLANK. Increment the rest counter on each tick.
    - At a tick with the count at REST_TICKS-1: go to BEAT_IN if run==1, else IDLE.
- run is examined only in IDLE and at the final REST tick. Deasserting run mid-beat completes the beat and its REST, then goes to IDLE. Re-asserting run during REST has no early effect.
- Outputs update in the same cycle as the state register. Frame F is visible on line/an_en for exactly P cycles (worst-case 1 cycle when P clamps to 1).
- Steady-state beat period = (3 + REST_TICKS) * P cycles.
- Simultaneous reset==0 and tick: reset wins.

Optional Feature:
- Macro: HEARTBEAT_DOUBLE_EN.
- When defined ("lub-dub" mode):
  - BEAT_BACK goes to GAP (BLANK, 1 tick) instead of REST.
  - GAP goes to BEAT2_IN (INNER, 1 tick), then BEAT2_OUT (OUTER, 1 tick; beat pulses on entry), then REST.
  - Period = (6 + REST_TICKS) * P.
- When undefined: GAP/BEAT2_* states and their encodings do not exist, and behaviour is exactly as above.

Decomposition:
- Shared package `seven_seg_pkg`:
  - state enum/localparams for all states, including the optional ones under the macro;
  - frame constants AN_BLANK/AN_INNER/AN_OUTER and LINE_INNER/LINE_OUTER.
- One sub-module, `heartbeat_tick_gen`:
  - prescaler plus rs_q latch;
  - inputs: clk, reset, enable, rate_sel;
  - output: a one-cycle tick.
- The FSM and output registers stay in the top module.

Test Plan:
- TICK_DIV=4, REST_TICKS=2, rate_sel=0, run held 1 after reset release:
  - cycles 1-4 show INNER (0110/0010), 5-8 OUTER (1001/0001), 9-12 INNER, 13-20 BLANK, then repeat with 20-cycle period;
  - beat is high only in cycle 5, 25, ...
- Same setup, drop run during BEAT_OUT: the beat finishes, REST lasts 8 cycles, then IDLE with an_en=0000 and busy=0; no further beat pulses.
- rate_sel changes 0→1 mid-BEAT_IN: the current frame still lasts 4 cycles and subsequent frames last 2 cycles. rate_sel=3 with TICK_DIV=4: each frame lasts 1 cycle (clamp).
- Assert reset (0) for 1 cycle during BEAT_BACK: next cycle IDLE, BLANK, beat=0, prescaler 0. With run=1 the sequence restarts at BEAT_IN with a full 4-cycle frame.
- HEARTBEAT_DOUBLE_EN defined, TICK_DIV=4, REST_TICKS=2:
  - sequence is INNER, OUTER, INNER, BLANK, INNER, OUTER, then BLANK×2 frames;
  - period is 32 cycles; beat pulses in cycles 5 and 21.
